// File: rtl/inst_wait_stage.sv
// Fetch wait stage: pairs issued fetch requests with their in-order responses and
// queues {pc, inst, exception} for decode. `IF_WAIT_SKID_EN selects a 2-deep output queue.
module inst_wait_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        ready_o,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        cancelled_i,
  input  logic        exc_i,
  input  logic        exc_miss_i,
  input  logic [4:0]  exccode_i,
  input  logic        commit_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        exc_o,
  output logic        exc_miss_o,
  output logic [4:0]  exccode_o,
  output logic [31:0] perfcnt_fetch_waitdata
);

`ifdef IF_WAIT_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic        exc_miss;
    logic [4:0]  exccode;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, WAIT, FULL} slot_state_t;

  slot_state_t state_reg, state_next;
  entry_t      slot_reg, slot_next;
  entry_t      push_entry;
  entry_t      fifo_reg  [DEPTH];
  entry_t      fifo_next [DEPTH];
  logic [1:0]  fifo_cnt_reg, fifo_cnt_next, cnt_after_pop;
  logic [1:0]  drop_cnt_reg, drop_cnt_next;
  logic [1:0]  drop_inc;
  logic        drop_dec;
  logic [31:0] perf_reg;
  logic        stall, route, done, pop, space, push, accept;

  // Reserved hold-off term; nothing drives it today.
  assign stall    = 1'b0;

  // Responses owed to flushed requests are swallowed before any reach the slot.
  assign route    = inst_data_ok && (drop_cnt_reg == 2'd0);
  assign drop_dec = inst_data_ok && (drop_cnt_reg != 2'd0);
  assign done     = (state_reg == FULL) || ((state_reg == WAIT) && route);
  assign valid_o  = (fifo_cnt_reg != 2'd0);
  assign pop      = valid_o && ready_i;
  assign space    = (fifo_cnt_reg < 2'(DEPTH)) || pop;
  assign push     = done && space;
  assign ready_o  = commit_i || (((state_reg == EMPTY) || (done && space)) && !stall);
  assign accept   = valid_i && ready_o;

  always_comb begin
    push_entry      = slot_reg;
    if (state_reg == WAIT) push_entry.inst = inst_rdata;
  end

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    if (done && space) begin
      state_next = EMPTY;
    end else if (done) begin
      state_next = FULL;
      if (state_reg == WAIT) slot_next.inst = inst_rdata;
    end
    if (accept && !commit_i && !cancelled_i) begin
      if (exc_i) begin
        state_next = FULL;
        slot_next  = '{pc: pc_i, inst: 32'd0, exc: 1'b1, exc_miss: exc_miss_i, exccode: exccode_i};
      end else begin
        state_next = WAIT;
        slot_next  = '{pc: pc_i, inst: 32'd0, exc: 1'b0, exc_miss: 1'b0, exccode: 5'd0};
      end
    end
    if (commit_i) state_next = EMPTY;
  end

  // A flush orphans the waiting request and any non-exception entry offered alongside it.
  always_comb begin
    drop_inc = 2'd0;
    if (commit_i)
      drop_inc = {1'b0, (state_reg == WAIT) && !route} + {1'b0, valid_i && !exc_i};
    else if (accept && cancelled_i && !exc_i)
      drop_inc = 2'd1;
    drop_cnt_next = drop_cnt_reg + drop_inc - {1'b0, drop_dec};
  end

  always_comb begin
    fifo_next     = fifo_reg;
    cnt_after_pop = fifo_cnt_reg - {1'b0, pop};
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) fifo_next[i] = fifo_reg[i + 1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (cnt_after_pop == 2'(i))) fifo_next[i] = push_entry;
    end
    fifo_cnt_next = commit_i ? 2'd0 : (cnt_after_pop + {1'b0, push});
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= EMPTY;
      slot_reg     <= '0;
      drop_cnt_reg <= 2'd0;
      fifo_cnt_reg <= 2'd0;
      perf_reg     <= 32'd0;
    end else begin
      state_reg    <= state_next;
      slot_reg     <= slot_next;
      drop_cnt_reg <= drop_cnt_next;
      fifo_cnt_reg <= fifo_cnt_next;
      if ((state_reg == WAIT) && !route) perf_reg <= perf_reg + 32'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (!resetn) fifo_reg[gi] <= '0;
        else         fifo_reg[gi] <= fifo_next[gi];
      end
    end
  endgenerate

  assign pc_o                   = fifo_reg[0].pc;
  assign inst_o                 = fifo_reg[0].inst;
  assign exc_o                  = fifo_reg[0].exc;
  assign exc_miss_o             = fifo_reg[0].exc_miss;
  assign exccode_o              = fifo_reg[0].exccode;
  assign perfcnt_fetch_waitdata = perf_reg;

endmodule

// File: tb/tb_inst_wait_stage.sv
// Directed bench for inst_wait_stage: per-cycle vector table plus hand-written
// perf-counter and mid-operation reset sequences.
module tb_inst_wait_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic        ready_o;
  logic        valid_i = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic        cancelled_i = 1'b0;
  logic        exc_i = 1'b0;
  logic        exc_miss_i = 1'b0;
  logic [4:0]  exccode_i = 5'd0;
  logic        commit_i = 1'b0;
  logic        ready_i = 1'b1;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        exc_o;
  logic        exc_miss_o;
  logic [4:0]  exccode_o;
  logic [31:0] perfcnt_fetch_waitdata;

  always #5 clk = ~clk;

  inst_wait_stage dut (
    .clk(clk), .resetn(resetn),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .ready_o(ready_o), .valid_i(valid_i), .pc_i(pc_i),
    .cancelled_i(cancelled_i), .exc_i(exc_i), .exc_miss_i(exc_miss_i),
    .exccode_i(exccode_i), .commit_i(commit_i), .ready_i(ready_i),
    .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .exc_o(exc_o),
    .exc_miss_o(exc_miss_o), .exccode_o(exccode_o),
    .perfcnt_fetch_waitdata(perfcnt_fetch_waitdata)
  );

`ifdef IF_WAIT_SKID_EN
  localparam bit SK = 1'b1;
`else
  localparam bit SK = 1'b0;
`endif

  typedef struct {
    string       name;
    bit          v;
    logic [31:0] pc;
    bit          canc, exc, excm;
    logic [4:0]  code;
    bit          cm, dok;
    logic [31:0] rd;
    bit          rdy;
    bit          er, ev;
    logic [31:0] epc, einst;
    bit          eexc, eexcm;
    logic [4:0]  ecode;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   ovf_errs = 0;

  function automatic vec_t V(string n, bit v, logic [31:0] pc, bit canc, bit exc, bit excm,
                             logic [4:0] code, bit cm, bit dok, logic [31:0] rd, bit rdy,
                             bit er, bit ev, logic [31:0] epc, logic [31:0] einst,
                             bit eexc, bit eexcm, logic [4:0] ecode);
    vec_t r;
    r.name = n; r.v = v; r.pc = pc; r.canc = canc; r.exc = exc; r.excm = excm; r.code = code;
    r.cm = cm; r.dok = dok; r.rd = rd; r.rdy = rdy; r.er = er; r.ev = ev;
    r.epc = epc; r.einst = einst; r.eexc = eexc; r.eexcm = eexcm; r.ecode = ecode;
    return r;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; pc_i = 32'd0; cancelled_i = 1'b0; exc_i = 1'b0; exc_miss_i = 1'b0;
    exccode_i = 5'd0; commit_i = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0; ready_i = 1'b1;
  endtask

  // drop_cnt must never be asked to hold a fourth outstanding discard.
  always @(negedge clk) begin
    if (resetn) begin
      assert (({1'b0, dut.drop_cnt_reg} + {1'b0, dut.drop_inc}) <= (3'd3 + {2'b0, dut.drop_dec}))
      else begin
        $display("FAIL drop_cnt_overflow: cnt %0d inc %0d dec %0d", dut.drop_cnt_reg, dut.drop_inc, dut.drop_dec);
        ovf_errs++;
      end
    end
  end

  initial begin
    int perf0;

    // Stream: four requests, responses one cycle behind, decode always ready
    vecs.push_back(V("st0", 1, 32'h8000_0000, 0,0,0,0, 0,0,0, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("st1", 1, 32'h8000_0004, 0,0,0,0, 0,1,32'h11, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("st2", 1, 32'h8000_0008, 0,0,0,0, 0,1,32'h22, 1,  1,1, 32'h8000_0000,32'h11,0,0,0));
    vecs.push_back(V("st3", 1, 32'h8000_000C, 0,0,0,0, 0,1,32'h33, 1,  1,1, 32'h8000_0004,32'h22,0,0,0));
    vecs.push_back(V("st4", 0, 0,             0,0,0,0, 0,1,32'h44, 1,  1,1, 32'h8000_0008,32'h33,0,0,0));
    vecs.push_back(V("st5", 0, 0,             0,0,0,0, 0,0,0,      1,  1,1, 32'h8000_000C,32'h44,0,0,0));
    vecs.push_back(V("st6", 0, 0,             0,0,0,0, 0,0,0,      1,  1,0, 0,0,0,0,0));
    // Exception entries, including a cancelled one that must vanish
    vecs.push_back(V("ex0", 1, 32'h8000_0002, 0,1,0,5'h04, 0,0,0, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("ex1", 0, 0,             0,0,0,0,     0,0,0, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("ex2", 0, 0,             0,0,0,0,     0,0,0, 1,  1,1, 32'h8000_0002,0,1,0,5'h04));
    vecs.push_back(V("ex3", 1, 32'h8000_0006, 1,1,1,5'h02, 0,0,0, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("ex4", 0, 0,             0,0,0,0,     0,0,0, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("ex5", 1, 32'h8000_000A, 0,1,1,5'h02, 0,0,0, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("ex6", 0, 0,             0,0,0,0,     0,0,0, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("ex7", 0, 0,             0,0,0,0,     0,0,0, 1,  1,1, 32'h8000_000A,0,1,1,5'h02));
    vecs.push_back(V("ex8", 0, 0,             0,0,0,0,     0,0,0, 1,  1,0, 0,0,0,0,0));
    // Flush drop: drop_cnt climbs to 3, fourth response reaches decode
    vecs.push_back(V("fl0", 1, 32'h100,       0,0,0,0, 0,0,0,          1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("fl1", 1, 32'h104,       0,0,0,0, 1,0,0,          1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("fl2", 1, 32'h108,       1,0,0,0, 0,0,0,          1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("fl3", 1, 32'hBFC0_0380, 0,0,0,0, 0,0,0,          1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("fl4", 0, 0,             0,0,0,0, 0,1,32'hAAAA,   1,  0,0, 0,0,0,0,0));
    vecs.push_back(V("fl5", 0, 0,             0,0,0,0, 0,1,32'hBBBB,   1,  0,0, 0,0,0,0,0));
    vecs.push_back(V("fl6", 0, 0,             0,0,0,0, 0,1,32'hCCCC,   1,  0,0, 0,0,0,0,0));
    vecs.push_back(V("fl7", 0, 0,             0,0,0,0, 0,1,32'hDEAD,   1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("fl8", 0, 0,             0,0,0,0, 0,0,0,          1,  1,1, 32'hBFC0_0380,32'hDEAD,0,0,0));
    vecs.push_back(V("fl9", 0, 0,             0,0,0,0, 0,0,0,          1,  1,0, 0,0,0,0,0));
    // Response in the commit cycle is eaten by the slot; nothing left to drop
    vecs.push_back(V("sm0", 1, 32'h200, 0,0,0,0, 0,0,0,        1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("sm1", 0, 0,       0,0,0,0, 1,1,32'h5555, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("sm2", 0, 0,       0,0,0,0, 0,0,0,        1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("sm3", 1, 32'h300, 0,0,0,0, 0,0,0,        1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("sm4", 0, 0,       0,0,0,0, 0,1,32'h77,   1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("sm5", 0, 0,       0,0,0,0, 0,0,0,        1,  1,1, 32'h300,32'h77,0,0,0));
    vecs.push_back(V("sm6", 0, 0,       0,0,0,0, 0,0,0,        1,  1,0, 0,0,0,0,0));
    // Commit empties a non-empty output queue
    vecs.push_back(V("fq0", 1, 32'h400, 0,0,0,0, 0,0,0,      1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("fq1", 0, 0,       0,0,0,0, 0,1,32'h40, 1,  1,0, 0,0,0,0,0));
    vecs.push_back(V("fq2", 0, 0,       0,0,0,0, 1,0,0,      0,  1,1, 32'h400,32'h40,0,0,0));
    vecs.push_back(V("fq3", 0, 0,       0,0,0,0, 0,0,0,      1,  1,0, 0,0,0,0,0));
    // Backpressure: decode stalls three cycles while two responses land
    vecs.push_back(V("bp0", 1, 32'h500, 0,0,0,0, 0,0,0,      1,  1, 0, 0,0,0,0,0));
    vecs.push_back(V("bp1", 1, 32'h504, 0,0,0,0, 0,1,32'h50, 0,  1, 0, 0,0,0,0,0));
    vecs.push_back(V("bp2", 0, 0,       0,0,0,0, 0,1,32'h54, 0,  SK,1, 32'h500,32'h50,0,0,0));
    vecs.push_back(V("bp3", 0, 0,       0,0,0,0, 0,0,0,      0,  SK,1, 32'h500,32'h50,0,0,0));
    vecs.push_back(V("bp4", 0, 0,       0,0,0,0, 0,0,0,      1,  1, 1, 32'h500,32'h50,0,0,0));
    vecs.push_back(V("bp5", 0, 0,       0,0,0,0, 0,0,0,      1,  1, 1, 32'h504,32'h54,0,0,0));
    vecs.push_back(V("bp6", 0, 0,       0,0,0,0, 0,0,0,      1,  1, 0, 0,0,0,0,0));

    // Reset state
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst.valid_o", 32'(valid_o), 32'd0);
    chk("rst.ready_o", 32'(ready_o), 32'd1);
    chk("rst.pc_o", pc_o, 32'd0);
    chk("rst.inst_o", inst_o, 32'd0);
    chk("rst.exc", {29'd0, exc_o, exc_miss_o, 1'b0}, 32'd0);
    chk("rst.exccode_o", 32'(exccode_o), 32'd0);
    chk("rst.perf", perfcnt_fetch_waitdata, 32'd0);
    $display("reset: valid_o=%0b ready_o=%0b perf=%0d", valid_o, ready_o, perfcnt_fetch_waitdata);

    foreach (vecs[k]) begin
      @(negedge clk);
      valid_i = vecs[k].v; pc_i = vecs[k].pc; cancelled_i = vecs[k].canc;
      exc_i = vecs[k].exc; exc_miss_i = vecs[k].excm; exccode_i = vecs[k].code;
      commit_i = vecs[k].cm; inst_data_ok = vecs[k].dok; inst_rdata = vecs[k].rd;
      ready_i = vecs[k].rdy;
      #1;
      chk({vecs[k].name, ".ready_o"}, 32'(ready_o), 32'(vecs[k].er));
      chk({vecs[k].name, ".valid_o"}, 32'(valid_o), 32'(vecs[k].ev));
      if (vecs[k].ev) begin
        chk({vecs[k].name, ".pc_o"}, pc_o, vecs[k].epc);
        chk({vecs[k].name, ".inst_o"}, inst_o, vecs[k].einst);
        chk({vecs[k].name, ".exc_o"}, 32'(exc_o), 32'(vecs[k].eexc));
        chk({vecs[k].name, ".exc_miss_o"}, 32'(exc_miss_o), 32'(vecs[k].eexcm));
        chk({vecs[k].name, ".exccode_o"}, 32'(exccode_o), 32'(vecs[k].ecode));
      end
      $display("%s: ready_o=%0b valid_o=%0b pc_o=%h inst_o=%h exc=%0b/%0b code=%h",
               vecs[k].name, ready_o, valid_o, pc_o, inst_o, exc_o, exc_miss_o, exccode_o);
    end

    // Perf: slot waits five cycles before its response
    @(negedge clk);
    idle_inputs();
    perf0 = int'(perfcnt_fetch_waitdata);
    valid_i = 1'b1; pc_i = 32'h600;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (c == 3) chk("perf.mid", perfcnt_fetch_waitdata, 32'(perf0 + 2));
    end
    @(negedge clk);
    inst_data_ok = 1'b1; inst_rdata = 32'h66;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("perf.delta", perfcnt_fetch_waitdata, 32'(perf0 + 5));
    chk("perf.valid_o", 32'(valid_o), 32'd1);
    chk("perf.pc_o", pc_o, 32'h600);
    chk("perf.inst_o", inst_o, 32'h66);
    $display("perf: start=%0d now=%0d pc_o=%h inst_o=%h", perf0, perfcnt_fetch_waitdata, pc_o, inst_o);

    // Reset while a request is waiting
    @(negedge clk);
    valid_i = 1'b1; pc_i = 32'h700;
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("mrst.valid_o", 32'(valid_o), 32'd0);
    chk("mrst.ready_o", 32'(ready_o), 32'd1);
    chk("mrst.perf", perfcnt_fetch_waitdata, 32'd0);
    chk("mrst.pc_o", pc_o, 32'd0);
    $display("midreset: valid_o=%0b ready_o=%0b perf=%0d", valid_o, ready_o, perfcnt_fetch_waitdata);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total + ovf_errs);
    $finish;
  end

endmodule
